dual_port_memory: RTL and testbench

Parametrised simple-dual-port RAM: one write port with byte strobes, one registered read port with valid and error flags, and a built-in sequential clear engine that zeroes the array after reset or on request. It is the next-generation storage primitive for datapath buffers and register files in the design. It replaces single-port, combinational-read, tri-stated-output memories wherever a synthesisable, timing-clean RAM is needed.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_clear_ctrl.sv | 90 +++++++++
 rtl/dual_port_memory.sv | 128 ++++++++++++
 tb/tb_dual_port_memory.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the dual_port_memory storage primitive.
//   clr_state_t : states of the array clear engine (CLEAR sweeps, IDLE serves)
//   strb_w_of   : number of byte strobes for a given data width
//   strb_merge  : one byte lane of a strobed write (new byte where strobe set)
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

  // Byte strobe count for a data width that is a multiple of 8.
  function automatic int strb_w_of(input int data_width);
    return data_width / 8;
  endfunction

  // Merge one byte lane: take the new byte when its strobe is set.
  function automatic logic [7:0] strb_merge(
    input logic [7:0] old_byte,
    input logic [7:0] new_byte,
    input logic       strb
  );
    logic [7:0] merged;
    if (strb) begin
      merged = new_byte;
    end else begin
      merged = old_byte;
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_clear_ctrl.sv
// ---------------------------------------------------------------------------
// mem_clear_ctrl
// Clear engine for dual_port_memory. After reset, and on every clr pulse,
// it sweeps the array from address 0 to DEPTH-1 writing zeros, one word per
// cycle, and holds busy high for the whole sweep.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   clr         : single-cycle request to (re)start a sweep
//   busy        : registered, high while sweeping or in reset
//   clear_we    : zero-write strobe for the array write port
//   clear_addr  : address of the zero write
// ---------------------------------------------------------------------------
module mem_clear_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_t            state_r;
  clr_state_t            state_nxt_s;
  logic [ADDR_WIDTH-1:0] ptr_r;
  logic [ADDR_WIDTH-1:0] ptr_nxt_s;
  logic                  busy_r;
  logic                  busy_nxt_s;

  // State, sweep pointer and busy registers; reset always begins a new sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLEAR;
      ptr_r   <= '0;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Next-state logic: busy drops on the same edge as the final zero write.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    busy_nxt_s  = busy_r;
    case (state_r)
      CLEAR: begin
        if (clr) begin
          ptr_nxt_s  = '0;
          busy_nxt_s = 1'b1;
        end else if (ptr_r == LAST_PTR) begin
          state_nxt_s = IDLE;
          ptr_nxt_s   = '0;
          busy_nxt_s  = 1'b0;
        end else begin
          ptr_nxt_s  = ptr_r + ADDR_WIDTH'(1);
          busy_nxt_s = 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          state_nxt_s = CLEAR;
          ptr_nxt_s   = '0;
          busy_nxt_s  = 1'b1;
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = CLEAR;
        ptr_nxt_s   = '0;
        busy_nxt_s  = 1'b1;
      end
    endcase
  end

  // The zero write happens in every CLEAR cycle except while reset is held.
  assign clear_we   = (state_r == CLEAR) && !rst;
  assign clear_addr = ptr_r;
  assign busy       = busy_r;

endmodule

// File: rtl/dual_port_memory.sv
// ---------------------------------------------------------------------------
// dual_port_memory
// Simple-dual-port RAM: one byte-strobed write port, one registered read
// port with valid/error flags, and a built-in clear sweep (mem_clear_ctrl)
// that zeroes the array after reset or on a clr pulse.
// Ports:
//   clk, rst         : clock and synchronous active-high reset
//   clr, busy        : clear request pulse / sweep-in-progress flag
//   we, waddr, wdata, wstrb : write port; out-of-range writes are dropped
//   re, raddr        : read request, answered one cycle later
//   rvalid, rdata, rerr : read response; rerr flags raddr >= DEPTH
// Build option:
//   MEM_RD_FWD_EN    : defined -> a same-address read during a write returns
//                      the merged new word; undefined -> returns the old word
//                      (read-first, block-RAM friendly).
// ---------------------------------------------------------------------------
module dual_port_memory
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  output logic                    busy,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rerr
);

  localparam int STRB_W = strb_w_of(DATA_WIDTH);
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

  logic                  busy_s;
  logic                  clear_we_s;
  logic [ADDR_WIDTH-1:0] clear_addr_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  rd_in_range_s;
  logic                  fwd_hit_s;
  logic [DATA_WIDTH-1:0] old_word_s;
  logic [DATA_WIDTH-1:0] wr_word_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  rvalid_r;
  logic                  rerr_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  mem_clear_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .busy       (busy_s),
    .clear_we   (clear_we_s),
    .clear_addr (clear_addr_s)
  );

  // User-port qualification, strobed merge and read-word selection.
  always_comb begin
    wr_en_s       = we && !busy_s && !rst && ({1'b0, waddr} < DEPTH_W);
    rd_en_s       = re && !busy_s && !rst;
    rd_in_range_s = ({1'b0, raddr} < DEPTH_W);
`ifdef MEM_RD_FWD_EN
    fwd_hit_s     = wr_en_s && (waddr == raddr);
`else
    fwd_hit_s     = 1'b0;
`endif
    old_word_s = mem_r[waddr];
    wr_word_s  = old_word_s;
    for (int i = 0; i < STRB_W; i++) begin
      wr_word_s[8*i +: 8] = strb_merge(old_word_s[8*i +: 8], wdata[8*i +: 8], wstrb[i]);
    end
    if (!rd_in_range_s) begin
      rd_word_s = '0;
    end else if (fwd_hit_s) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = mem_r[raddr];
    end
  end

  // Array write port: the clear sweep owns the port while it runs.
  always_ff @(posedge clk) begin
    if (clear_we_s) begin
      mem_r[clear_addr_s] <= '0;
    end else if (wr_en_s) begin
      mem_r[waddr] <= wr_word_s;
    end else begin
      mem_r[waddr] <= mem_r[waddr];
    end
  end

  // Registered read response; rdata keeps its last value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r <= 1'b0;
      rerr_r   <= 1'b0;
      rdata_r  <= '0;
    end else begin
      rvalid_r <= rd_en_s;
      rerr_r   <= rd_en_s && !rd_in_range_s;
      if (rd_en_s) begin
        rdata_r <= rd_word_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign busy   = busy_s;
  assign rvalid = rvalid_r;
  assign rerr   = rerr_r;
  assign rdata  = rdata_r;

endmodule

// File: tb/tb_dual_port_memory.sv
// ---------------------------------------------------------------------------
// tb_dual_port_memory
// Self-checking bench: a DEPTH=16 instance carries most checks; a DEPTH=12
// instance sharing the same stimulus covers the out-of-range address rules.
// ---------------------------------------------------------------------------
module tb_dual_port_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        we;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        re;
  logic [3:0]  raddr;

  logic        busy16, rvalid16, rerr16;
  logic [31:0] rdata16;
  logic        busy12, rvalid12, rerr12;
  logic [31:0] rdata12;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] model16 [16];
  logic [31:0] model12 [12];
  logic [31:0] hold16, hold12;
  logic        exp_v, exp_e12;
  bit          fwd;

  typedef struct {
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        re;
    logic [3:0]  raddr;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic        exp_rerr;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  dual_port_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy16),
    .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .re(re), .raddr(raddr),
    .rvalid(rvalid16), .rdata(rdata16), .rerr(rerr16)
  );

  dual_port_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12)) u_dut12 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy12),
    .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .re(re), .raddr(raddr),
    .rvalid(rvalid12), .rdata(rdata12), .rerr(rerr12)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic idle_in();
    we = 1'b0; re = 1'b0; clr = 1'b0;
    waddr = 4'd0; raddr = 4'd0; wdata = 32'd0; wstrb = 4'd0;
  endtask

  function automatic vec_t mk(input logic w, input logic [3:0] wa, input logic [31:0] wd,
                              input logic [3:0] ws, input logic r, input logic [3:0] ra,
                              input logic ev, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.wstrb = ws; v.re = r; v.raddr = ra;
    v.exp_rvalid = ev; v.exp_rdata = ed; v.exp_rerr = ee;
    return v;
  endfunction

  // Byte-strobe write as mask arithmetic on whole words.
  function automatic logic [31:0] apply_strb(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  // Reference model for one idle (not busy) cycle using the current inputs.
  task automatic model_cycle();
    logic [31:0] old16, old12;
    bool_same: begin end
    old16   = model16[raddr];
    old12   = (raddr < 4'd12) ? model12[raddr] : 32'd0;
    exp_v   = re;
    exp_e12 = re && (raddr >= 4'd12);
    if (we) begin
      model16[waddr] = apply_strb(model16[waddr], wdata, wstrb);
      if (waddr < 4'd12) model12[waddr] = apply_strb(model12[waddr], wdata, wstrb);
    end
    if (re) begin
      hold16 = (fwd && we && waddr == raddr) ? model16[raddr] : old16;
      if (raddr >= 4'd12) hold12 = 32'd0;
      else hold12 = (fwd && we && waddr == raddr) ? model12[raddr] : old12;
    end
  endtask

  initial begin
    int cnt;
    int seen;
    logic [31:0] same_exp;
`ifdef MEM_RD_FWD_EN
    fwd = 1'b1;
`else
    fwd = 1'b0;
`endif
    same_exp = fwd ? 32'h1234_5678 : 32'h0000_0000;
    for (int i = 0; i < 16; i++) model16[i] = 32'd0;
    for (int i = 0; i < 12; i++) model12[i] = 32'd0;
    hold16 = 32'd0; hold12 = 32'd0;

    // Reset state
    rst = 1'b1;
    idle_in();
    repeat (3) step();
    check_b("rst busy", busy16, 1'b1);
    check_b("rst rvalid", rvalid16, 1'b0);
    check_w("rst rdata", rdata16, 32'd0);
    check_b("rst rerr", rerr16, 1'b0);

    // Sweep length after release
    rst = 1'b0;
    cnt = 0;
    while (busy16 && cnt < 40) begin
      cnt++;
      step();
    end
    check_w("reset sweep length", 32'(cnt), 32'd16);

    // Table-driven vectors (DEPTH=16 instance)
    vq.push_back(mk(1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd5,  1'b1, 32'h0000_0000, 1'b0));
    vq.push_back(mk(1'b1, 4'd3,  32'hDEAD_BEEF, 4'hF, 1'b0, 4'd0,  1'b0, 32'h0000_0000, 1'b0));
    vq.push_back(mk(1'b1, 4'd3,  32'h1122_3344, 4'h5, 1'b0, 4'd0,  1'b0, 32'h0000_0000, 1'b0));
    vq.push_back(mk(1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd3,  1'b1, 32'hDE22_BE44, 1'b0));
    vq.push_back(mk(1'b1, 4'd7,  32'h1234_5678, 4'hF, 1'b1, 4'd7,  1'b1, same_exp,      1'b0));
    vq.push_back(mk(1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd7,  1'b1, 32'h1234_5678, 1'b0));
    vq.push_back(mk(1'b1, 4'd4,  32'hFFFF_FFFF, 4'h0, 1'b1, 4'd4,  1'b1, 32'h0000_0000, 1'b0));
    vq.push_back(mk(1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd4,  1'b1, 32'h0000_0000, 1'b0));
    vq.push_back(mk(1'b1, 4'd15, 32'hCAFE_F00D, 4'hA, 1'b1, 4'd14, 1'b1, 32'h0000_0000, 1'b0));
    vq.push_back(mk(1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd15, 1'b1, 32'hCA00_F000, 1'b0));
    vq.push_back(mk(1'b0, 4'd0,  32'h0,         4'h0, 1'b0, 4'd0,  1'b0, 32'hCA00_F000, 1'b0));
    vq.push_back(mk(1'b1, 4'd9,  32'h0000_BEEF, 4'h3, 1'b1, 4'd15, 1'b1, 32'hCA00_F000, 1'b0));
    vq.push_back(mk(1'b0, 4'd0,  32'h0,         4'h0, 1'b1, 4'd9,  1'b1, 32'h0000_BEEF, 1'b0));
    for (int i = 0; i < vq.size(); i++) begin
      we = vq[i].we; waddr = vq[i].waddr; wdata = vq[i].wdata; wstrb = vq[i].wstrb;
      re = vq[i].re; raddr = vq[i].raddr;
      model_cycle();
      step();
      check_b($sformatf("vec%0d rvalid", i), rvalid16, vq[i].exp_rvalid);
      check_w($sformatf("vec%0d rdata", i), rdata16, vq[i].exp_rdata);
      check_b($sformatf("vec%0d rerr", i), rerr16, vq[i].exp_rerr);
    end
    idle_in();

    // Out-of-range addresses on the DEPTH=12 instance
    we = 1'b1; waddr = 4'd13; wdata = 32'hAAAA_AAAA; wstrb = 4'hF;
    model_cycle(); step(); idle_in();
    re = 1'b1; raddr = 4'd13;
    model_cycle(); step();
    check_b("d12 oor rvalid", rvalid12, 1'b1);
    check_b("d12 oor rerr", rerr12, 1'b1);
    check_w("d12 oor rdata", rdata12, 32'd0);
    check_w("d16 addr13 rdata", rdata16, 32'hAAAA_AAAA);
    raddr = 4'd1;
    model_cycle(); step();
    check_w("d12 no alias rdata", rdata12, 32'd0);
    raddr = 4'd11;
    model_cycle(); step();
    check_b("d12 last rvalid", rvalid12, 1'b1);
    check_b("d12 last rerr", rerr12, 1'b0);
    check_w("d12 last rdata", rdata12, 32'd0);
    idle_in();

    // Randomized traffic against the reference model (both instances)
    for (int k = 0; k < 300; k++) begin
      we    = 1'($urandom_range(0, 1));
      re    = 1'($urandom_range(0, 1));
      raddr = 4'($urandom_range(0, 15));
      waddr = ($urandom_range(0, 1) == 0) ? raddr : 4'($urandom_range(0, 15));
      wdata = $urandom();
      wstrb = 4'($urandom_range(0, 15));
      model_cycle();
      step();
      check_b("rand d16 rvalid", rvalid16, exp_v);
      check_w("rand d16 rdata", rdata16, hold16);
      check_b("rand d16 rerr", rerr16, 1'b0);
      check_b("rand d12 rvalid", rvalid12, exp_v);
      check_w("rand d12 rdata", rdata12, hold12);
      check_b("rand d12 rerr", rerr12, exp_e12);
    end
    idle_in();

    // clr sweep with traffic injected while busy (DEPTH=16 instance only)
    we = 1'b1; waddr = 4'd2; wdata = 32'h7777_7777; wstrb = 4'hF; step();
    waddr = 4'd3; wdata = 32'h8888_8888; step();
    idle_in();
    clr = 1'b1; step(); clr = 1'b0;
    cnt = 0; seen = 0;
    while (busy16 && cnt < 40) begin
      cnt++;
      if (cnt == 3 || cnt == 16) begin
        we = 1'b1; waddr = 4'd2; wdata = 32'h5555_5555; wstrb = 4'hF; re = 1'b1; raddr = 4'd3;
      end else begin
        idle_in();
      end
      step();
      if (rvalid16) seen++;
    end
    idle_in();
    check_w("clr sweep length", 32'(cnt), 32'd16);
    check_w("rvalid while busy", 32'(seen), 32'd0);
    re = 1'b1; raddr = 4'd2; step();
    check_b("post clr rvalid", rvalid16, 1'b1);
    check_w("post clr addr2", rdata16, 32'd0);
    raddr = 4'd3; step();
    check_w("post clr addr3", rdata16, 32'd0);
    idle_in();

    // rst in the middle of a sweep, together with clr and re
    we = 1'b1; waddr = 4'd5; wdata = 32'h0BAD_CAFE; wstrb = 4'hF; step();
    idle_in(); re = 1'b1; raddr = 4'd5; step();
    check_w("pre abort rdata", rdata16, 32'h0BAD_CAFE);
    idle_in();
    clr = 1'b1; step(); clr = 1'b0;
    repeat (8) step();
    rst = 1'b1; clr = 1'b1; re = 1'b1; raddr = 4'd5;
    step();
    check_b("abort busy", busy16, 1'b1);
    check_b("abort rvalid", rvalid16, 1'b0);
    check_w("abort rdata", rdata16, 32'd0);
    check_b("abort rerr", rerr16, 1'b0);
    step();
    check_b("abort rvalid hold", rvalid16, 1'b0);
    rst = 1'b0;
    idle_in();
    cnt = 0;
    while (busy16 && cnt < 40) begin
      cnt++;
      step();
    end
    check_w("abort sweep length", 32'(cnt), 32'd16);
    re = 1'b1; raddr = 4'd5; step();
    check_b("after abort rvalid", rvalid16, 1'b1);
    check_w("after abort rdata", rdata16, 32'd0);
    idle_in();
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
